// File: rtl/digit_entry_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : digit_entry_ctrl_pkg
// Brief    : Shared button indices, digit width and FSM state type for the
//            digit entry controller.
// Revision : 1.0 - initial release
// ============================================================================
package digit_entry_ctrl_pkg;

    localparam int DIGIT_W     = 4;
    localparam int NUM_BTNS    = 5;

    localparam int BTN_RIGHT   = 0;
    localparam int BTN_LEFT    = 1;
    localparam int BTN_UP      = 2;
    localparam int BTN_DOWN    = 3;
    localparam int BTN_CONFIRM = 4;

    typedef enum logic [0:0] {
        ST_EDIT = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage : digit_entry_ctrl_pkg
`default_nettype wire

// File: rtl/digit_entry_ctrl_btn_edge.sv
`default_nettype none
// ============================================================================
// Module   : btn_edge
// Brief    : Per-bit rising-edge detector against a registered level copy.
// Revision : 1.0 - initial release
// ============================================================================
module btn_edge
    import digit_entry_ctrl_pkg::*;
#(
    parameter int WIDTH = NUM_BTNS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] lvl_i,
    output logic [WIDTH-1:0] edge_o
);

    logic [WIDTH-1:0] hist_q;
    logic [WIDTH-1:0] hist_d;

    always_comb begin
        hist_d = lvl_i;
    end

    // History clears on reset so a level held through reset release yields one edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign edge_o = lvl_i & ~hist_q;

endmodule : btn_edge
`default_nettype wire

// File: rtl/digit_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : digit_entry_ctrl
// Brief    : Button-driven multi-digit entry with commit/ready handshake.
//            Optional auto-repeat of up/down: DIGIT_ENTRY_AUTO_REPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module digit_entry_ctrl
    import digit_entry_ctrl_pkg::*;
#(
    parameter int DIGITS        = 8,
    parameter int RADIX         = 10,
    parameter int SATURATE      = 1,
    parameter int CLR_ON_ACCEPT = 1
`ifdef DIGIT_ENTRY_AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DLY    = 50_000_000,
    parameter int REPEAT_PER    = 10_000_000
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_BTNS-1:0]        btn_i,
    input  logic                       clr_i,
    input  logic                       ready_i,
    output logic [DIGIT_W*DIGITS-1:0]  data_o,
    output logic [$clog2(DIGITS)-1:0]  sel_o,
    output logic                       valid_o
);

    localparam int SEL_W = $clog2(DIGITS);

    state_t                     state_q, state_d;
    logic [SEL_W-1:0]           sel_q, sel_d;
    logic [DIGIT_W*DIGITS-1:0]  data_q, data_d;
    logic [NUM_BTNS-1:0]        btn_edge_w;
    logic [NUM_BTNS-1:0]        ev;
    logic [DIGIT_W-1:0]         cur_digit;

    btn_edge #(
        .WIDTH (NUM_BTNS)
    ) u_btn_edge (
        .clk    (clk),
        .rst    (rst),
        .lvl_i  (btn_i),
        .edge_o (btn_edge_w)
    );

`ifdef DIGIT_ENTRY_AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_first_q, rpt_first_d;
    logic             rpt_up, rpt_dn;
    logic             hold_up, hold_dn;

    // Counter holds the number of consecutive high cycles, the edge cycle counting as one.
    always_comb begin
        hold_up     = btn_i[BTN_UP]   & ~btn_edge_w[BTN_UP];
        hold_dn     = btn_i[BTN_DOWN] & ~btn_edge_w[BTN_DOWN];
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b1;
        rpt_up      = 1'b0;
        rpt_dn      = 1'b0;
        if (state_q == ST_EDIT) begin
            if (btn_edge_w[BTN_UP] || btn_edge_w[BTN_DOWN]) begin
                rpt_cnt_d = RPT_W'(1);
            end else if (hold_up || hold_dn) begin
                rpt_first_d = rpt_first_q;
                rpt_cnt_d   = rpt_cnt_q + 1'b1;
                if (rpt_cnt_d == (rpt_first_q ? RPT_W'(REPEAT_DLY) : RPT_W'(REPEAT_PER))) begin
                    rpt_cnt_d   = '0;
                    rpt_first_d = 1'b0;
                    rpt_up      = hold_up;
                    rpt_dn      = ~hold_up;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b1;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
        end
    end

    assign ev = btn_edge_w | {1'b0, rpt_dn, rpt_up, 2'b00};
`else
    assign ev = btn_edge_w;
`endif

    assign cur_digit = data_q[DIGIT_W*sel_q +: DIGIT_W];

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        data_d  = data_q;
        case (state_q)
            ST_EDIT: begin
                if (clr_i) begin
                    sel_d  = '0;
                    data_d = '0;
                end else if (ev[BTN_RIGHT]) begin
                    sel_d = (sel_q == SEL_W'(DIGITS - 1)) ? '0 : sel_q + 1'b1;
                end else if (ev[BTN_LEFT]) begin
                    sel_d = (sel_q == '0) ? SEL_W'(DIGITS - 1) : sel_q - 1'b1;
                end else if (ev[BTN_UP]) begin
                    if (cur_digit == DIGIT_W'(RADIX - 1)) begin
                        data_d[DIGIT_W*sel_q +: DIGIT_W] = (SATURATE != 0) ? cur_digit : '0;
                    end else begin
                        data_d[DIGIT_W*sel_q +: DIGIT_W] = cur_digit + 1'b1;
                    end
                end else if (ev[BTN_DOWN]) begin
                    if (cur_digit == '0) begin
                        data_d[DIGIT_W*sel_q +: DIGIT_W] = (SATURATE != 0) ? '0 : DIGIT_W'(RADIX - 1);
                    end else begin
                        data_d[DIGIT_W*sel_q +: DIGIT_W] = cur_digit - 1'b1;
                    end
                end else if (ev[BTN_CONFIRM]) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Events and clr_i are dropped here; only the handshake matters.
                if (ready_i) begin
                    state_d = ST_EDIT;
                    if (CLR_ON_ACCEPT != 0) begin
                        sel_d  = '0;
                        data_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_EDIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EDIT;
            sel_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end

    assign data_o  = data_q;
    assign sel_o   = sel_q;
    assign valid_o = (state_q == ST_HOLD);

endmodule : digit_entry_ctrl
`default_nettype wire

// File: tb/tb_digit_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_entry_ctrl
// Brief    : Directed self-checking bench; dut saturates, dut_w wraps.
// Revision : 1.0 - initial release
// ============================================================================
module tb_digit_entry_ctrl;

    localparam logic [4:0] B_R = 5'b00001;
    localparam logic [4:0] B_L = 5'b00010;
    localparam logic [4:0] B_U = 5'b00100;
    localparam logic [4:0] B_C = 5'b10000;
    localparam logic [4:0] B_D = 5'b01000;

    localparam int RPT_DLY  = 6;
    localparam int RPT_PER  = 3;
    localparam int RPT_HOLD = RPT_DLY + 3 * RPT_PER;
`ifdef DIGIT_ENTRY_AUTO_REPEAT_EN
    localparam logic [31:0] EXP_RPT = 32'h0000_0005;
`else
    localparam logic [31:0] EXP_RPT = 32'h0000_0001;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  btn = 5'b0;
    logic        clr = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] data_a, data_b;
    logic [2:0]  sel_a, sel_b;
    logic        valid_a, valid_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    digit_entry_ctrl #(
`ifdef DIGIT_ENTRY_AUTO_REPEAT_EN
        .REPEAT_DLY (RPT_DLY),
        .REPEAT_PER (RPT_PER),
`endif
        .SATURATE   (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn),
        .clr_i   (clr),
        .ready_i (ready),
        .data_o  (data_a),
        .sel_o   (sel_a),
        .valid_o (valid_a)
    );

    digit_entry_ctrl #(
        .SATURATE (0)
    ) dut_w (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn),
        .clr_i   (clr),
        .ready_i (ready),
        .data_o  (data_b),
        .sel_o   (sel_b),
        .valid_o (valid_b)
    );

    task automatic do_reset();
        rst = 1'b0; btn = '0; clr = 1'b0; ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic press(input logic [4:0] b);
        @(negedge clk) btn = b;
        @(negedge clk) btn = 5'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; btn = B_R; clr = 1'b0; ready = 1'b0;
        #2;
        n_cmp++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid_a); end
        n_cmp++; if (sel_a !== 3'd0) begin n_err++; $display("FAIL reset_sel: got %0d want 0", sel_a); end
        n_cmp++; if (data_a !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", data_a); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++; if (sel_a !== 3'd1) begin n_err++; $display("FAIL held_through_reset_sel: got %0d want 1", sel_a); end
        btn = 5'b0;
    endtask

    task automatic test_basic();
        do_reset();
        repeat (3) press(B_R);
        repeat (2) press(B_U);
        n_cmp++; if (sel_a !== 3'd3) begin n_err++; $display("FAIL basic_sel: got %0d want 3", sel_a); end
        n_cmp++; if (data_a !== 32'h0000_2000) begin n_err++; $display("FAIL basic_data: got %h want 00002000", data_a); end
        n_cmp++; if (data_b !== 32'h0000_2000) begin n_err++; $display("FAIL basic_data_w: got %h want 00002000", data_b); end
    endtask

    task automatic test_saturate();
        do_reset();
        repeat (11) press(B_U);
        n_cmp++; if (data_a !== 32'h9) begin n_err++; $display("FAIL sat_up11: got %h want 9", data_a); end
        n_cmp++; if (data_b !== 32'h1) begin n_err++; $display("FAIL wrap_up11: got %h want 1", data_b); end
        press(B_U);
        n_cmp++; if (data_a !== 32'h9) begin n_err++; $display("FAIL sat_up12: got %h want 9", data_a); end
        n_cmp++; if (data_b !== 32'h2) begin n_err++; $display("FAIL wrap_up12: got %h want 2", data_b); end
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        press(B_D);
        n_cmp++; if (data_a !== 32'h0) begin n_err++; $display("FAIL sat_down0: got %h want 0", data_a); end
        n_cmp++; if (data_b !== 32'h9) begin n_err++; $display("FAIL wrap_down0: got %h want 9", data_b); end
    endtask

    task automatic test_wrap_priority();
        do_reset();
        press(B_L);
        n_cmp++; if (sel_a !== 3'd7) begin n_err++; $display("FAIL left_wrap: got %0d want 7", sel_a); end
        press(B_R | B_U);
        n_cmp++; if (sel_a !== 3'd0) begin n_err++; $display("FAIL right_wrap: got %0d want 0", sel_a); end
        n_cmp++; if (data_a !== 32'h0) begin n_err++; $display("FAIL right_over_up: got %h want 0", data_a); end
        press(B_U | B_C);
        n_cmp++; if (data_a !== 32'h1) begin n_err++; $display("FAIL up_over_confirm_data: got %h want 1", data_a); end
        n_cmp++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL up_over_confirm_valid: got %b want 0", valid_a); end
    endtask

    task automatic test_edit_ctrl();
        do_reset();
        press(B_R);
        press(B_U);
        @(negedge clk) ready = 1'b1;
        @(negedge clk) ready = 1'b0;
        n_cmp++; if (valid_a !== 1'b0 || data_a !== 32'h10 || sel_a !== 3'd1) begin
            n_err++; $display("FAIL ready_in_edit: got v=%b d=%h s=%0d want v=0 d=10 s=1", valid_a, data_a, sel_a);
        end
        @(negedge clk) begin clr = 1'b1; btn = B_R; end
        @(negedge clk) begin clr = 1'b0; btn = 5'b0; end
        n_cmp++; if (sel_a !== 3'd0 || data_a !== 32'h0) begin
            n_err++; $display("FAIL clr_priority: got d=%h s=%0d want d=0 s=0", data_a, sel_a);
        end
    endtask

    task automatic test_hold();
        do_reset();
        press(B_U);
        press(B_R);
        press(B_U);
        press(B_U);
        press(B_C);
        n_cmp++; if (valid_a !== 1'b1) begin n_err++; $display("FAIL hold_enter: got %b want 1", valid_a); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            btn = (i % 2 == 1) ? B_U : B_R;
            clr = (i == 3);
        end
        @(negedge clk) begin btn = 5'b0; clr = 1'b0; end
        n_cmp++; if (valid_a !== 1'b1 || data_a !== 32'h21 || sel_a !== 3'd1) begin
            n_err++; $display("FAIL hold_frozen: got v=%b d=%h s=%0d want v=1 d=21 s=1", valid_a, data_a, sel_a);
        end
        n_cmp++; if (valid_b !== 1'b1 || data_b !== 32'h21) begin
            n_err++; $display("FAIL hold_frozen_w: got v=%b d=%h want v=1 d=21", valid_b, data_b);
        end
        @(negedge clk) ready = 1'b1;
        @(negedge clk) ready = 1'b0;
        n_cmp++; if (valid_a !== 1'b0 || data_a !== 32'h0 || sel_a !== 3'd0) begin
            n_err++; $display("FAIL accept_clear: got v=%b d=%h s=%0d want v=0 d=0 s=0", valid_a, data_a, sel_a);
        end
        repeat (3) @(negedge clk);
        n_cmp++; if (valid_a !== 1'b0 || data_a !== 32'h0 || sel_a !== 3'd0) begin
            n_err++; $display("FAIL no_queued_events: got v=%b d=%h s=%0d want v=0 d=0 s=0", valid_a, data_a, sel_a);
        end
    endtask

    task automatic test_repeat();
        do_reset();
        @(negedge clk) btn = B_U;
        repeat (RPT_HOLD) @(negedge clk);
        btn = 5'b0;
        @(negedge clk);
        n_cmp++; if (data_a !== EXP_RPT) begin n_err++; $display("FAIL repeat_hold: got %h want %h", data_a, EXP_RPT); end
        n_cmp++; if (data_b !== 32'h1) begin n_err++; $display("FAIL repeat_hold_long_dly: got %h want 1", data_b); end
    endtask

    task automatic test_async_reset();
        do_reset();
        press(B_U);
        press(B_C);
        n_cmp++; if (valid_a !== 1'b1 || data_a !== 32'h1) begin
            n_err++; $display("FAIL pre_async_hold: got v=%b d=%h want v=1 d=1", valid_a, data_a);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (valid_a !== 1'b0 || data_a !== 32'h0) begin
            n_err++; $display("FAIL async_reset: got v=%b d=%h want v=0 d=0", valid_a, data_a);
        end
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL commit_abandoned: got %b want 0", valid_a); end
    endtask

    initial begin
        #100_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_wrap_priority();
        test_edit_ctrl();
        test_hold();
        test_repeat();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_digit_entry_ctrl
`default_nettype wire
